// File: rtl/vga_board_decoder.sv
// Recovers a Connect-Four board and cursor from a 640x480@60 VGA pixel stream.
// The timing geometry is parameterised; the defaults are the real 800x525 raster.
module vga_board_decoder #(
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC_START = 656,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC_START = 490,
    parameter int V_COMMIT     = 480,
    parameter int GRID_X0      = 208,
    parameter int GRID_Y0      = 128,
    parameter int CELL_LOG2    = 5,
    parameter int CURSOR_Y     = 80
) (
    input  logic        clk_25MHz,
    input  logic        rst,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic [1:0]  vga_r,
    input  logic [1:0]  vga_g,
    input  logic [1:0]  vga_b,
    output logic [63:0] board_p1,
    output logic [63:0] board_p2,
    output logic [2:0]  cursor_col,
    output logic [1:0]  cursor_player,
    output logic        cursor_valid,
    output logic        frame_valid,
    output logic        locked,
    output logic        sync_error,
    output logic        color_error
);

    localparam logic [1:0] UNLOCKED = 2'd0;
    localparam logic [1:0] HSEEN    = 2'd1;
    localparam logic [1:0] LOCKED   = 2'd2;

    localparam logic [9:0] X_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_HSYNC   = 10'(H_SYNC_START);
    localparam logic [9:0] Y_VSYNC   = 10'(V_SYNC_START);
    localparam logic [9:0] Y_COMMIT  = 10'(V_COMMIT);
    localparam logic [9:0] X_GRID0   = 10'(GRID_X0);
    localparam logic [9:0] Y_GRID0   = 10'(GRID_Y0);
    localparam logic [9:0] Y_CURSOR  = 10'(CURSOR_Y);
    localparam logic [9:0] GRID_SPAN = 10'(8 << CELL_LOG2);

    logic [1:0]  state, state_next;
    logic [9:0]  x, y, x_load, y_load, x_next, y_next;
    logic        hs_s1, vs_s1, hs_prev, vs_prev;
    logic [1:0]  r_s1, g_s1, b_s1;
    logic        hs_fall, vs_fall, sync_err_next, is_locked;
    logic [9:0]  x_off, y_off;
    logic        on_col, on_row, cell_hit, cursor_hit;
    logic [2:0]  col_idx, row_sel;
    logic [5:0]  cell_idx;
    logic        is_yellow, is_red, is_bg, pixel_bad;
    logic        full_frame, frame_start, commit;
    logic [63:0] shadow_p1, shadow_p2;
    logic [7:0]  cur_mask, cur_p2;
    logic [3:0]  cur_count;
    logic [2:0]  cur_sel;
    logic        cur_one, cur_multi;

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            hs_s1   <= 1'b0;
            vs_s1   <= 1'b0;
            r_s1    <= 2'b00;
            g_s1    <= 2'b00;
            b_s1    <= 2'b00;
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            hs_s1   <= vga_hsync;
            vs_s1   <= vga_vsync;
            r_s1    <= vga_r;
            g_s1    <= vga_g;
            b_s1    <= vga_b;
            hs_prev <= hs_s1;
            vs_prev <= vs_s1;
        end
    end

    assign hs_fall   = hs_prev & ~hs_s1;
    assign vs_fall   = vs_prev & ~vs_s1;
    assign is_locked = (state == LOCKED);
    assign locked    = is_locked;

    // Sync falls re-anchor the counters for the current sample before it advances.
    always_comb begin
        state_next    = state;
        x_load        = x;
        y_load        = y;
        sync_err_next = 1'b0;
        case (state)
            UNLOCKED: begin
                if (hs_fall) begin
                    x_load     = X_HSYNC;
                    state_next = HSEEN;
                end
            end
            HSEEN: begin
                if (hs_fall)
                    x_load = X_HSYNC;
                if (vs_fall) begin
                    x_load     = 10'd0;
                    y_load     = Y_VSYNC;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if ((hs_fall && x != X_HSYNC) ||
                    (vs_fall && (x != 10'd0 || y != Y_VSYNC))) begin
                    sync_err_next = 1'b1;
                    state_next    = UNLOCKED;
                end
            end
            default: state_next = UNLOCKED;
        endcase
        x_next = (x_load == X_LAST) ? 10'd0 : x_load + 10'd1;
        y_next = y_load;
        if (x_load == X_LAST)
            y_next = (y_load == Y_LAST) ? 10'd0 : y_load + 10'd1;
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state <= UNLOCKED;
            x     <= 10'd0;
            y     <= 10'd0;
        end else begin
            state <= state_next;
            x     <= x_next;
            y     <= y_next;
        end
    end

    // Out-of-range offsets wrap to large values, so one compare covers both ends.
    assign x_off      = x - X_GRID0;
    assign y_off      = y - Y_GRID0;
    assign on_col     = (x_off < GRID_SPAN) && (x_off[CELL_LOG2-1:0] == '0);
    assign on_row     = (y_off < GRID_SPAN) && (y_off[CELL_LOG2-1:0] == '0);
    assign col_idx    = x_off[CELL_LOG2 +: 3];
    assign row_sel    = y_off[CELL_LOG2 +: 3];
    assign cell_idx   = {~row_sel, col_idx};
    assign cell_hit   = is_locked && on_col && on_row;
    assign cursor_hit = is_locked && on_col && (y == Y_CURSOR);

    assign is_yellow = ({r_s1, g_s1, b_s1} == 6'b11_11_00);
    assign is_red    = ({r_s1, g_s1, b_s1} == 6'b11_00_00);
    assign is_bg     = ({r_s1, g_s1, b_s1} == 6'b01_11_01);
    assign pixel_bad = ~(is_yellow | is_red | is_bg);

    assign frame_start = is_locked && (x == 10'd0) && (y == 10'd0);
    assign commit      = is_locked && full_frame && (x == 10'd0) && (y == Y_COMMIT);

    always_ff @(posedge clk_25MHz) begin
        if (rst || frame_start) begin
            shadow_p1 <= '0;
            shadow_p2 <= '0;
            cur_mask  <= '0;
            cur_p2    <= '0;
        end else begin
            if (cell_hit) begin
                shadow_p1[cell_idx] <= is_yellow;
                shadow_p2[cell_idx] <= is_red;
            end
            if (cursor_hit) begin
                cur_mask[col_idx] <= is_yellow | is_red;
                cur_p2[col_idx]   <= is_red;
            end
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst)
            full_frame <= 1'b0;
        else if (state_next != LOCKED)
            full_frame <= 1'b0;
        else if (frame_start)
            full_frame <= 1'b1;
        else if (commit)
            full_frame <= 1'b0;
    end

    always_comb begin
        cur_count = 4'd0;
        cur_sel   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (cur_mask[i]) begin
                cur_count = cur_count + 4'd1;
                cur_sel   = 3'(i);
            end
        end
        cur_one   = (cur_count == 4'd1);
        cur_multi = (cur_count > 4'd1);
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            board_p1      <= '0;
            board_p2      <= '0;
            cursor_col    <= 3'd0;
            cursor_player <= 2'b00;
            cursor_valid  <= 1'b0;
            frame_valid   <= 1'b0;
            sync_error    <= 1'b0;
            color_error   <= 1'b0;
        end else begin
            frame_valid <= commit;
            sync_error  <= sync_err_next;
            color_error <= ((cell_hit || cursor_hit) && pixel_bad) || (commit && cur_multi);
            if (commit) begin
                board_p1      <= shadow_p1;
                board_p2      <= shadow_p2;
                cursor_valid  <= cur_one;
                cursor_col    <= cur_one ? cur_sel : 3'd0;
                cursor_player <= cur_one ? (cur_p2[cur_sel] ? 2'b10 : 2'b01) : 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_vga_board_decoder.sv
// Directed bench for vga_board_decoder on a shrunken raster (64x44, 4-pixel cells)
// so that many complete frames fit in a short run.
module tb_vga_board_decoder;

    localparam int HT = 64, HS = 48, VT = 44, VS = 40, VC = 36;
    localparam int GX = 8, GY = 4, CL = 2, CY = 2;

    logic        clk, rst, hs, vs;
    logic [1:0]  r, g, b;
    logic [63:0] board_p1, board_p2;
    logic [2:0]  cursor_col;
    logic [1:0]  cursor_player;
    logic        cursor_valid, frame_valid, locked, sync_error, color_error;

    int checks = 0, fails = 0;
    int fv_count = 0, se_count = 0, ce_count = 0;
    int fv_x = -1, fv_y = -1, se_x = -1, se_y = -1;
    int cur_x = 0, cur_y = 0, shift_line = -1;
    logic [1:0] cell_cfg [64];
    logic [1:0] cur_cfg [8];

    vga_board_decoder #(
        .H_TOTAL(HT), .H_SYNC_START(HS), .V_TOTAL(VT), .V_SYNC_START(VS),
        .V_COMMIT(VC), .GRID_X0(GX), .GRID_Y0(GY), .CELL_LOG2(CL), .CURSOR_Y(CY)
    ) dut (
        .clk_25MHz(clk), .rst(rst), .vga_hsync(hs), .vga_vsync(vs),
        .vga_r(r), .vga_g(g), .vga_b(b),
        .board_p1(board_p1), .board_p2(board_p2), .cursor_col(cursor_col),
        .cursor_player(cursor_player), .cursor_valid(cursor_valid),
        .frame_valid(frame_valid), .locked(locked),
        .sync_error(sync_error), .color_error(color_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts events and remembers which raw pixel was on the inputs.
    always @(negedge clk) begin
        if (frame_valid) begin
            fv_count++;
            fv_x = cur_x;
            fv_y = cur_y;
        end
        if (sync_error) begin
            se_count++;
            se_x = cur_x;
            se_y = cur_y;
        end
        if (color_error)
            ce_count++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 64; i++) cell_cfg[i] = 2'd0;
        for (int i = 0; i < 8; i++) cur_cfg[i] = 2'd0;
        shift_line = -1;
    endtask

    // Colour codes: 0 background, 1 yellow, 2 red, 3 illegal grey.
    task automatic set_colour(input int code);
        case (code)
            0:       {r, g, b} = 6'b01_11_01;
            1:       {r, g, b} = 6'b11_11_00;
            2:       {r, g, b} = 6'b11_00_00;
            3:       {r, g, b} = 6'b10_10_10;
            default: {r, g, b} = 6'b00_00_00;
        endcase
    endtask

    task automatic drive_lines(input int y0, input int y1);
        int hlo, code, c, s;
        for (int yy = y0; yy <= y1; yy++) begin
            for (int xx = 0; xx < HT; xx++) begin
                cur_x = xx;
                cur_y = yy;
                hlo = (yy == shift_line) ? HS + 3 : HS;
                hs = !(xx >= hlo && xx < hlo + 8);
                vs = !(yy == VS || yy == VS + 1);
                code = -1;
                if (xx >= GX && xx <= GX + 28 && (xx - GX) % 4 == 0) begin
                    c = (xx - GX) / 4;
                    if (yy == CY)
                        code = cur_cfg[c];
                    else if (yy >= GY && yy <= GY + 28 && (yy - GY) % 4 == 0) begin
                        s = (yy - GY) / 4;
                        code = cell_cfg[(7 - s) * 8 + c];
                    end
                end
                set_colour(code);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " board_p1"}, board_p1, 64'd0);
        check({tag, " board_p2"}, board_p2, 64'd0);
        check({tag, " cursor_col"}, 64'(cursor_col), 64'd0);
        check({tag, " cursor_player"}, 64'(cursor_player), 64'd0);
        check({tag, " cursor_valid"}, 64'(cursor_valid), 64'd0);
        check({tag, " frame_valid"}, 64'(frame_valid), 64'd0);
        check({tag, " locked"}, 64'(locked), 64'd0);
        check({tag, " sync_error"}, 64'(sync_error), 64'd0);
        check({tag, " color_error"}, 64'(color_error), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        hs = 1'b1;
        vs = 1'b1;
        {r, g, b} = 6'd0;
        clear_cfg();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Empty board, player 1 cursor in column 0: lock, then commit one frame later.
        cur_cfg[0] = 2'd1;
        drive_lines(0, VT - 1);
        check("A locked", 64'(locked), 64'd1);
        check("A no commit yet", 64'(fv_count), 64'd0);
        drive_lines(0, VT - 1);
        check("A commit", 64'(fv_count), 64'd1);
        check("A latency x", 64'(fv_x), 64'd2);
        check("A latency y", 64'(fv_y), 64'(VC));
        check("A board_p1", board_p1, 64'd0);
        check("A board_p2", board_p2, 64'd0);
        check("A cursor_valid", 64'(cursor_valid), 64'd1);
        check("A cursor_col", 64'(cursor_col), 64'd0);
        check("A cursor_player", 64'(cursor_player), 64'd1);

        // P1 at (row0,col3), P2 at (row7,col7), player 2 cursor in column 5.
        clear_cfg();
        cell_cfg[3] = 2'd1;
        cell_cfg[63] = 2'd2;
        cur_cfg[5] = 2'd2;
        drive_lines(0, VT - 1);
        check("B commit", 64'(fv_count), 64'd2);
        check("B board_p1", board_p1, 64'h8);
        check("B board_p2", board_p2, 64'h8000_0000_0000_0000);
        check("B cursor_valid", 64'(cursor_valid), 64'd1);
        check("B cursor_col", 64'(cursor_col), 64'd5);
        check("B cursor_player", 64'(cursor_player), 64'd2);

        // Game over: same board, no cursor drawn.
        cur_cfg[5] = 2'd0;
        drive_lines(0, VT - 1);
        check("C commit", 64'(fv_count), 64'd3);
        check("C board_p1", board_p1, 64'h8);
        check("C board_p2", board_p2, 64'h8000_0000_0000_0000);
        check("C cursor_valid", 64'(cursor_valid), 64'd0);
        check("C cursor_player", 64'(cursor_player), 64'd0);
        check("C color_error", 64'(ce_count), 64'd0);

        // Two cursors plus one illegal cursor colour; extra P1 piece at (row2,col1).
        cell_cfg[17] = 2'd1;
        cur_cfg[1] = 2'd1;
        cur_cfg[4] = 2'd2;
        cur_cfg[6] = 2'd3;
        drive_lines(0, VT - 1);
        check("E commit", 64'(fv_count), 64'd4);
        check("E board_p1", board_p1, 64'h2_0008);
        check("E cursor_valid", 64'(cursor_valid), 64'd0);
        check("E cursor_player", 64'(cursor_player), 64'd0);
        check("E color_error", 64'(ce_count), 64'd2);

        // Illegal colour in cell (row2,col1), player 1 cursor in column 2.
        for (int i = 0; i < 8; i++) cur_cfg[i] = 2'd0;
        cell_cfg[17] = 2'd3;
        cur_cfg[2] = 2'd1;
        drive_lines(0, VT - 1);
        check("D commit", 64'(fv_count), 64'd5);
        check("D color_error", 64'(ce_count), 64'd3);
        check("D board_p1", board_p1, 64'h8);
        check("D board_p2", board_p2, 64'h8000_0000_0000_0000);
        check("D cursor_valid", 64'(cursor_valid), 64'd1);
        check("D cursor_col", 64'(cursor_col), 64'd2);
        check("D cursor_player", 64'(cursor_player), 64'd1);

        // Hsync shifted by 3 pixels on line 20: lose lock, skip this frame's commit.
        cell_cfg[17] = 2'd2;
        cur_cfg[2] = 2'd0;
        cur_cfg[7] = 2'd2;
        shift_line = 20;
        drive_lines(0, 25);
        check("F sync_error count", 64'(se_count), 64'd1);
        check("F sync_error x", 64'(se_x), 64'(HS + 5));
        check("F sync_error y", 64'(se_y), 64'd20);
        check("F unlocked", 64'(locked), 64'd0);
        drive_lines(26, VT - 1);
        check("F relocked", 64'(locked), 64'd1);
        check("F no commit", 64'(fv_count), 64'd5);
        check("F hold cursor_col", 64'(cursor_col), 64'd2);
        check("F hold cursor_player", 64'(cursor_player), 64'd1);
        shift_line = -1;
        drive_lines(0, VT - 1);
        check("G commit", 64'(fv_count), 64'd6);
        check("G board_p2", board_p2, 64'h8000_0000_0002_0000);
        check("G cursor_col", 64'(cursor_col), 64'd7);
        check("G cursor_player", 64'(cursor_player), 64'd2);
        check("G sync_error count", 64'(se_count), 64'd1);

        // Reset at line 30: everything clears, no commit until relock plus a full frame.
        drive_lines(0, 29);
        rst = 1'b1;
        hs = 1'b1;
        vs = 1'b1;
        {r, g, b} = 6'd0;
        @(posedge clk);
        #1;
        check_all_zero("mid reset");
        rst = 1'b0;
        drive_lines(30, VT - 1);
        check("R relocked", 64'(locked), 64'd1);
        check("R no commit", 64'(fv_count), 64'd6);
        drive_lines(0, VT - 1);
        check("R commit", 64'(fv_count), 64'd7);
        check("R board_p1", board_p1, 64'h8);
        check("R board_p2", board_p2, 64'h8000_0000_0002_0000);
        check("R cursor_col", 64'(cursor_col), 64'd7);
        check("R color_error", 64'(ce_count), 64'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
